// File: rtl/fu_pipe.sv
// Two-stage pipelined functional unit with an operand register bank, valid/ready
// handshakes on both sides, optional write-back and a combinational hazard interlock.
module fu_pipe #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       instruction,
    input  logic [SEL_W-1:0] src_x,
    input  logic [SEL_W-1:0] src_y,
    input  logic             wb_en,
    input  logic [SEL_W-1:0] wb_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_flag
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_XSUB = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_MAX  = 3'd4,
        OP_MIN  = 3'd5,
        OP_ROR  = 3'd6,
        OP_ROL  = 3'd7
    } op_e;

    logic [WIDTH-1:0] bank [NREG];

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x, s1_y;
    op_e              s1_op;
    logic             s1_wb_en;
    logic [SEL_W-1:0] s1_wb_addr;

    logic             out_wb_en;
    logic [SEL_W-1:0] out_wb_addr;

    op_e              enc_op;
    logic             adv2, out_fire, accept, haz;
    logic             haz_s1, haz_out;
    logic [WIDTH-1:0] add_a, add_b, alu_f;
    logic [WIDTH:0]   sum;
    logic             alu_flag, x_lt_y;

    // Highest set bit wins; an all-zero instruction falls through to ADD.
    always_comb begin
        enc_op = OP_ADD;
        for (int unsigned i = 0; i < 8; i++) begin
            if (instruction[i]) enc_op = op_e'(i[2:0]);
        end
    end

    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign out_fire = out_valid && out_ready;
    assign haz_s1   = s1_valid && s1_wb_en && (src_x == s1_wb_addr || src_y == s1_wb_addr);
    assign haz_out  = out_valid && out_wb_en && (src_x == out_wb_addr || src_y == out_wb_addr);
    assign haz      = haz_s1 || haz_out;
    assign in_ready = (!s1_valid || adv2) && !haz;
    assign accept   = in_valid && in_ready;

    // All adding ops share one WIDTH+1-bit adder; its top bit is the carry flag.
    always_comb begin
        add_a = s1_x;
        add_b = s1_y;
        case (s1_op)
            OP_ROL:  add_a = {s1_x[WIDTH-2:0], s1_x[WIDTH-1]};
            OP_ROR:  add_a = {s1_x[0], s1_x[WIDTH-1:1]};
            OP_XSUB: add_b = ~s1_y;
            default: ;
        endcase
        sum    = {1'b0, add_a} + {1'b0, add_b};
        x_lt_y = s1_x < s1_y;
        alu_f    = sum[WIDTH-1:0];
        alu_flag = sum[WIDTH];
        case (s1_op)
            OP_MIN: begin
                alu_f    = x_lt_y ? s1_x : s1_y;
                alu_flag = x_lt_y;
            end
            OP_MAX: begin
                alu_f    = x_lt_y ? s1_y : s1_x;
                alu_flag = x_lt_y;
            end
            OP_OR: begin
                alu_f    = s1_x | s1_y;
                alu_flag = 1'b0;
            end
            OP_AND: begin
                alu_f    = s1_x & s1_y;
                alu_flag = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_op      <= OP_ADD;
            s1_wb_en   <= 1'b0;
            s1_wb_addr <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_x       <= bank[src_x];
            s1_y       <= bank[src_y];
            s1_op      <= enc_op;
            s1_wb_en   <= wb_en;
            s1_wb_addr <= wb_addr;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_f       <= '0;
            out_flag    <= 1'b0;
            out_wb_en   <= 1'b0;
            out_wb_addr <= '0;
        end else if (adv2) begin
            out_valid   <= 1'b1;
            out_f       <= alu_f;
            out_flag    <= alu_flag;
            out_wb_en   <= s1_wb_en;
            out_wb_addr <= s1_wb_addr;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Write-back takes priority over an external load to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (out_fire && out_wb_en && out_wb_addr == SEL_W'(i))
                    bank[i] <= out_f;
                else if (wr_en && wr_addr == SEL_W'(i))
                    bank[i] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_fu_pipe.sv
// Directed bench for fu_pipe: an 8-bit/4-entry instance for the main scenarios and a
// 16-bit/8-entry instance for rotation width and mid-flight reset.
module tb_fu_pipe;

    logic        clk, rst_n;
    logic        wr_en, in_valid, in_ready, wb_en, out_valid, out_ready, out_flag;
    logic [1:0]  wr_addr, src_x, src_y, wb_addr;
    logic [7:0]  wr_data, instruction, out_f;

    logic        wr_en_w, in_valid_w, in_ready_w, wb_en_w, out_valid_w, out_ready_w, out_flag_w;
    logic [2:0]  wr_addr_w, src_x_w, src_y_w, wb_addr_w;
    logic [15:0] wr_data_w, out_f_w;
    logic [7:0]  instruction_w;

    int n_checks = 0;
    int n_pass   = 0;
    int t4_got   = 0;

    logic [7:0] t4_ins  [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [1:0] t4_x    [8] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd0};
    logic [1:0] t4_y    [8] = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [7:0] t4_f    [8] = '{8'h04, 8'hC1, 8'h10, 8'h20, 8'h91, 8'h01, 8'hEF, 8'h02};
    logic       t4_fl   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    fu_pipe #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
        .src_x(src_x), .src_y(src_y), .wb_en(wb_en), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_flag(out_flag)
    );

    fu_pipe #(.WIDTH(16), .NREG(8)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .instruction(instruction_w),
        .src_x(src_x_w), .src_y(src_y_w), .wb_en(wb_en_w), .wb_addr(wb_addr_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_f(out_f_w), .out_flag(out_flag_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Called at a falling edge; the load lands on the following rising edge.
    task automatic load(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] ins, input logic [1:0] x, input logic [1:0] y,
                        input logic we, input logic [1:0] wa);
        in_valid    = 1'b1;
        instruction = ins;
        src_x       = x;
        src_y       = y;
        wb_en       = we;
        wb_addr     = wa;
        #1;
        for (int c = 0; c < 40 && !in_ready; c++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] ef, input logic efl);
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && !out_valid; c++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_f"}, 32'(out_f), 32'(ef));
        check({tag, "_flag"}, 32'(out_flag), 32'(efl));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        {wr_en, in_valid, wb_en, out_ready} = '0;
        {wr_addr, src_x, src_y, wb_addr} = '0;
        wr_data = '0;
        instruction = '0;
        {wr_en_w, in_valid_w, wb_en_w, out_ready_w} = '0;
        {wr_addr_w, src_x_w, src_y_w, wb_addr_w} = '0;
        wr_data_w = '0;
        instruction_w = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_f", 32'(out_f), 0);
        check("rst_out_flag", 32'(out_flag), 0);
        check("rst_out_valid_w", 32'(out_valid_w), 0);

        // T1: ROL+ with two-cycle latency
        load(2'd0, 8'h81);
        load(2'd1, 8'h01);
        send(8'h80, 2'd0, 2'd1, 1'b0, 2'd0);
        check("t1_lat_early", 32'(out_valid), 0);
        @(negedge clk);
        #1;
        check("t1_lat_valid", 32'(out_valid), 1);
        recv("t1", 8'h04, 1'b0);

        // T2: XSUB and ADD carries
        load(2'd0, 8'h05);
        load(2'd1, 8'h03);
        send(8'h02, 2'd0, 2'd1, 1'b0, 2'd0);
        recv("t2_xsub", 8'h01, 1'b1);
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        send(8'h00, 2'd0, 2'd1, 1'b0, 2'd0);
        recv("t2_add", 8'h00, 1'b1);

        // T3: priority and MIN/MAX
        load(2'd0, 8'h10);
        load(2'd1, 8'h20);
        send(8'h30, 2'd0, 2'd1, 1'b0, 2'd0);
        recv("t3_min", 8'h10, 1'b1);
        send(8'h10, 2'd0, 2'd1, 1'b0, 2'd0);
        recv("t3_max", 8'h20, 1'b1);

        // T4: 8 back-to-back instructions against a toggling consumer
        load(2'd0, 8'h81);
        load(2'd1, 8'h01);
        load(2'd2, 8'h10);
        load(2'd3, 8'h20);
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    in_valid    = 1'b1;
                    instruction = t4_ins[i];
                    src_x       = t4_x[i];
                    src_y       = t4_y[i];
                    wb_en       = 1'b0;
                    #1;
                    for (int c = 0; c < 40 && !in_ready; c++) begin
                        @(negedge clk);
                        #1;
                    end
                    if (!in_ready) check("t4_send_timeout", 32'(in_ready), 1);
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && t4_got < 8; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        check($sformatf("t4_f%0d", t4_got), 32'(out_f), 32'(t4_f[t4_got]));
                        check($sformatf("t4_flag%0d", t4_got), 32'(out_flag), 32'(t4_fl[t4_got]));
                        t4_got++;
                    end
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        check("t4_count", 32'(t4_got), 8);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_drained", 32'(out_valid), 0);

        // T5: write-back hazard and write-back beating a same-edge load
        send(8'h01, 2'd0, 2'd1, 1'b1, 2'd2);
        in_valid    = 1'b1;
        instruction = 8'h01;
        src_x       = 2'd2;
        src_y       = 2'd1;
        wb_en       = 1'b0;
        #1;
        check("t5_haz_s1", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        check("t5_haz_out", 32'(in_ready), 0);
        check("t5_first_valid", 32'(out_valid), 1);
        check("t5_first_f", 32'(out_f), 'h82);
        out_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 2'd2;
        wr_data   = 8'h55;
        #1;
        check("t5_haz_hold", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        check("t5_ready_after", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        recv("t5_second", 8'h83, 1'b0);
        send(8'h08, 2'd2, 2'd2, 1'b0, 2'd0);
        recv("t5_b2", 8'h82, 1'b0);

        // T6: 16-bit ROR+ then reset with two instructions in flight
        wr_en_w   = 1'b1;
        wr_addr_w = 3'd0;
        wr_data_w = 16'h0001;
        @(negedge clk);
        wr_addr_w = 3'd1;
        wr_data_w = 16'h0000;
        @(negedge clk);
        wr_en_w       = 1'b0;
        in_valid_w    = 1'b1;
        instruction_w = 8'h40;
        src_x_w       = 3'd0;
        src_y_w       = 3'd1;
        #1;
        check("t6_in_ready", 32'(in_ready_w), 1);
        @(negedge clk);
        in_valid_w = 1'b0;
        check("t6_lat_early", 32'(out_valid_w), 0);
        @(negedge clk);
        #1;
        check("t6_ror_valid", 32'(out_valid_w), 1);
        check("t6_ror_f", 32'(out_f_w), 'h8000);
        check("t6_ror_flag", 32'(out_flag_w), 0);
        in_valid_w = 1'b1;
        wb_en_w    = 1'b1;
        wb_addr_w  = 3'd0;
        @(negedge clk);
        in_valid_w = 1'b0;
        wb_en_w    = 1'b0;
        check("t6_stalled", 32'(out_valid_w), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid_w", 32'(out_valid_w), 0);
        check("t6_rst_f_w", 32'(out_f_w), 0);
        check("t6_rst_in_ready_w", 32'(in_ready_w), 1);
        @(negedge clk);
        rst_n       = 1'b1;
        out_ready_w = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_ghost", 32'(out_valid_w), 0);
        in_valid_w    = 1'b1;
        instruction_w = 8'h01;
        src_x_w       = 3'd0;
        src_y_w       = 3'd0;
        @(negedge clk);
        in_valid_w = 1'b0;
        @(negedge clk);
        #1;
        check("t6_clear_valid", 32'(out_valid_w), 1);
        check("t6_clear_f", 32'(out_f_w), 0);
        check("t6_clear_flag", 32'(out_flag_w), 0);
        @(negedge clk);
        out_ready_w = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
